sme_rx_matcher: RTL and testbench

Receive-side string matching engine for the SME character-stream protocol. It captures a string sent with `isstring`, then any number of patterns sent with `ispattern`. After each pattern ends it searches the stored string and returns one `valid` pulse carrying `match` and `match_index`. It is the synthesizable responder that the SME stimulus driver and checker talk to.

---
 rtl/sme_pkg.sv | 17 +
 rtl/sme_window_cmp.sv | 51 +++++
 rtl/sme_rx_matcher.sv | 187 ++++++++++++++++++
 tb/tb_sme_rx_matcher.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared types and character constants for the SME receive-side matcher.
package sme_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_STR,
    ST_LOAD_PAT,
    ST_SEARCH,
    ST_DONE
  } sme_state_e;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/sme_window_cmp.sv
// Combinational hit test of the pattern core against one string window.
// win[0] holds S[s-1], win[1+i] holds S[s+i].
module sme_window_cmp
  import sme_pkg::*;
#(
  parameter int unsigned PAT_LEN = 8,
  parameter int unsigned SW      = 6
) (
  input  logic [PAT_LEN-1:0][7:0] pat,
  input  logic [$clog2(PAT_LEN):0] c_len,
  input  logic                     lead,
  input  logic                     trail,
  input  logic [PAT_LEN+1:0][7:0]  win,
  input  logic [SW-1:0]            s,
  input  logic [SW-1:0]            l,
  output logic                     hit
);

  localparam int unsigned EW = SW + 1;
  localparam int unsigned CW = $clog2(PAT_LEN) + 1;

  logic [EW-1:0] end_pos;
  logic [CW-1:0] pidx;
  logic [7:0]    pc;
  logic [7:0]    tail;

  // Window bytes past L are never read: s+C<=L bounds every core read,
  // the leading-anchor read (s-1) and the trailing read (only when s+C<L).
  // Evaluate every hit condition for the current start position.
  always_comb begin
    end_pos = EW'(s) + EW'(c_len);
    hit     = (c_len != '0) && (end_pos <= EW'(l));
    pidx    = '0;
    pc      = '0;
    tail    = '0;
    for (int unsigned i = 0; i < PAT_LEN; i++) begin
      if (CW'(i) < c_len) begin
        pidx = CW'(i) + CW'(lead);
        pc   = '0;
        if (pidx < CW'(PAT_LEN)) pc = pat[pidx[CW-2:0]];
        if ((pc != CH_DOT) && (pc != win[i+1])) hit = 1'b0;
      end
    end
    if (lead && (s != '0) && (win[0] != CH_SPACE)) hit = 1'b0;
    for (int unsigned k = 0; k <= PAT_LEN; k++) begin
      if (CW'(k) == c_len) tail = win[k+1];
    end
    if (trail && (end_pos != EW'(l)) && (tail != CH_SPACE)) hit = 1'b0;
  end

endmodule

// File: rtl/sme_rx_matcher.sv
// SME receive-side string matcher: stores a string, then searches it for
// each received pattern and reports one registered result per pattern.
module sme_rx_matcher
  import sme_pkg::*;
#(
  parameter int unsigned STR_LEN     = 32,
  parameter int unsigned PAT_LEN     = 8,
  parameter int unsigned MAX_STR_ADD = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             chardata,
  input  logic                   isstring,
  input  logic                   ispattern,
  output logic                   valid,
  output logic                   match,
  output logic [MAX_STR_ADD-1:0] match_index
);

  localparam int unsigned SW = MAX_STR_ADD + 1;
  localparam int unsigned EW = SW + 1;
  localparam int unsigned CW = $clog2(PAT_LEN) + 1;
  localparam int unsigned PW = $clog2(PAT_LEN);

  sme_state_e                  state_q, state_d;
  logic [STR_LEN-1:0][7:0]     str_q, str_d;
  logic [SW-1:0]               str_len_q, str_len_d;
  logic [PAT_LEN-1:0][7:0]     pat_q, pat_d;
  logic [CW-1:0]               pat_len_q, pat_len_d;
  logic [SW-1:0]               s_q, s_d;
  logic                        valid_q, valid_d;
  logic                        match_q, match_d;
  logic [MAX_STR_ADD-1:0]      idx_q, idx_d;

  logic [7:0]                  last_ch;
  logic                        lead;
  logic                        trail;
  logic [CW-1:0]               c_len;
  logic [PAT_LEN+1:0][7:0]     win;
  logic [EW-1:0]               pos;
  logic [MAX_STR_ADD-1:0]      widx;
  logic                        hit;
  logic                        idle_rules;

  // Anchor decode and core length of the stored pattern.
  always_comb begin
    last_ch = '0;
    for (int unsigned k = 0; k < PAT_LEN; k++) begin
      if (CW'(k + 1) == pat_len_q) last_ch = pat_q[k];
    end
    lead  = (pat_len_q != '0) && (pat_q[0] == CH_CARET);
    trail = (pat_len_q != '0) && (last_ch == CH_DOLLAR);
    c_len = pat_len_q - CW'(lead) - CW'(trail);
  end

  // Gather S[s-1 .. s+PAT_LEN]; positions outside the buffer read as zero.
  always_comb begin
    win  = '0;
    pos  = '0;
    widx = '0;
    for (int unsigned k = 0; k < PAT_LEN + 2; k++) begin
      pos  = EW'(s_q) + EW'(k);
      widx = MAX_STR_ADD'(pos - EW'(1));
      if ((pos != '0) && (pos <= EW'(STR_LEN))) win[k] = str_q[widx];
    end
  end

  sme_window_cmp #(
    .PAT_LEN (PAT_LEN),
    .SW      (SW)
  ) u_cmp (
    .pat   (pat_q),
    .c_len (c_len),
    .lead  (lead),
    .trail (trail),
    .win   (win),
    .s     (s_q),
    .l     (str_len_q),
    .hit   (hit)
  );

  // Next-state, buffer loading, search stepping and result latching.
  // Leaving LOAD_STR re-applies the IDLE decisions to the same inputs,
  // so both paths share the idle_rules block after the case.
  always_comb begin
    state_d    = state_q;
    str_d      = str_q;
    str_len_d  = str_len_q;
    pat_d      = pat_q;
    pat_len_d  = pat_len_q;
    s_d        = s_q;
    match_d    = match_q;
    idx_d      = idx_q;
    valid_d    = 1'b0;
    idle_rules = 1'b0;

    case (state_q)
      ST_IDLE: idle_rules = 1'b1;
      ST_LOAD_STR: begin
        if (isstring) begin
          if (str_len_q < SW'(STR_LEN)) begin
            str_d[str_len_q[MAX_STR_ADD-1:0]] = chardata;
            str_len_d = str_len_q + SW'(1);
          end
        end else begin
          idle_rules = 1'b1;
        end
      end
      ST_LOAD_PAT: begin
        if (ispattern) begin
          if (pat_len_q < CW'(PAT_LEN)) begin
            pat_d[pat_len_q[PW-1:0]] = chardata;
            pat_len_d = pat_len_q + CW'(1);
          end
        end else begin
          state_d = ST_SEARCH;
          s_d     = '0;
        end
      end
      ST_SEARCH: begin
        if ((str_len_q == '0) || (c_len == '0)) begin
          match_d = 1'b0;
          idx_d   = '0;
          state_d = ST_DONE;
        end else if (hit) begin
          match_d = 1'b1;
          idx_d   = s_q[MAX_STR_ADD-1:0];
          state_d = ST_DONE;
        end else if (s_q == str_len_q - SW'(1)) begin
          match_d = 1'b0;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          s_d = s_q + SW'(1);
        end
      end
      ST_DONE: begin
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (idle_rules) begin
      state_d = ST_IDLE;
      if (isstring) begin
        str_d[0]  = chardata;
        str_len_d = SW'(1);
        state_d   = ST_LOAD_STR;
      end else if (ispattern) begin
        pat_d[0]  = chardata;
        pat_len_d = CW'(1);
        state_d   = ST_LOAD_PAT;
      end
    end
  end

  // State, buffers and result registers; reset also invalidates the string.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      str_q     <= '0;
      str_len_q <= '0;
      pat_q     <= '0;
      pat_len_q <= '0;
      s_q       <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      str_q     <= str_d;
      str_len_q <= str_len_d;
      pat_q     <= pat_d;
      pat_len_q <= pat_len_d;
      s_q       <= s_d;
      valid_q   <= valid_d;
      match_q   <= match_d;
      idx_q     <= idx_d;
    end
  end

  assign valid       = valid_q;
  assign match       = match_q;
  assign match_index = idx_q;

endmodule

// File: tb/tb_sme_rx_matcher.sv
// Scoreboard bench for sme_rx_matcher: a string-level reference model
// predicts match, index and latency for every pattern sent.
module tb_sme_rx_matcher;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  typedef struct {
    bit    m;
    int    idx;
    int    lat;
    string name;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  string model_str = "";

  always #5 clk = ~clk;

  sme_rx_matcher #(
    .STR_LEN     (32),
    .PAT_LEN     (8),
    .MAX_STR_ADD (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: anchors, wildcard, saturation and latency from the protocol text.
  function automatic void ref_match(input string str, input string pat,
                                    output bit m, output int idx, output int lat);
    string p;
    string core;
    int    L;
    int    C;
    bit    ld;
    bit    tr;
    bit    ok;
    p    = (pat.len() > 8) ? pat.substr(0, 7) : pat;
    L    = str.len();
    ld   = (p.len() > 0) && (p[0] == 8'h5E);
    tr   = (p.len() > 0) && (p[p.len()-1] == 8'h24) && !(p.len() == 1 && ld);
    core = p.substr(ld ? 1 : 0, p.len() - 1 - (tr ? 1 : 0));
    C    = core.len();
    m    = 1'b0;
    idx  = 0;
    if (L == 0 || C == 0) begin
      lat = 2;
      return;
    end
    lat = 1 + L;
    for (int s = 0; s < L; s++) begin
      ok = (s + C <= L);
      for (int i = 0; i < C && ok; i++)
        if (core[i] != 8'h2E && core[i] != str[s+i]) ok = 1'b0;
      if (ok && ld && s != 0 && str[s-1] != 8'h20) ok = 1'b0;
      if (ok && tr && s + C != L && str[s+C] != 8'h20) ok = 1'b0;
      if (ok) begin
        m   = 1'b1;
        idx = s;
        lat = 2 + s;
        return;
      end
    end
  endfunction

  task automatic drive(input bit is_s, input bit is_p, input byte c);
    @(negedge clk);
    isstring  = is_s;
    ispattern = is_p;
    chardata  = c;
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) drive(1'b1, 1'b0, s[i]);
    model_str = (s.len() > 32) ? s.substr(0, 31) : s;
  endtask

  // Ends on the falling edge that drops ispattern; the next rising edge is T.
  task automatic send_pattern(input string pat, input bit expect_res);
    exp_t e;
    for (int i = 0; i < pat.len(); i++) drive(1'b0, 1'b1, pat[i]);
    @(negedge clk);
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    if (expect_res) begin
      ref_match(model_str, pat, e.m, e.idx, e.lat);
      e.name = pat;
      sb.push_back(e);
    end
  endtask

  task automatic wait_result();
    int   n    = 0;
    bit   seen = 1'b0;
    exp_t e;
    @(posedge clk);
    while (!seen && n < 80) begin
      @(posedge clk);
      n++;
      #1;
      if (valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: valid seen=%0b with no expected result queued", seen);
      return;
    end
    e = sb.pop_front();
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no valid after %0d cycles, required at cycle %0d", e.name, n, e.lat);
      return;
    end
    checks++;
    if (match !== e.m) begin
      errors++;
      $display("FAIL %s match: got %0b, required %0b", e.name, match, e.m);
    end
    checks++;
    if (match_index !== 5'(e.idx)) begin
      errors++;
      $display("FAIL %s index: got %0d, required %0d", e.name, match_index, e.idx);
    end
    checks++;
    if (n != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d, required %0d", e.name, n, e.lat);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL %s valid_width: got valid=%0b one cycle later, required 0", e.name, valid);
    end
    checks++;
    if (match !== e.m || match_index !== 5'(e.idx)) begin
      errors++;
      $display("FAIL %s hold: got %0b/%0d, required %0b/%0d", e.name, match, match_index, e.m, e.idx);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    isstring  = 1'b0;
    ispattern = 1'b0;
    chardata  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    checks++;
    if (match !== 1'b0) begin errors++; $display("FAIL reset_match: got %0b, required 0", match); end
    checks++;
    if (match_index !== 5'd0) begin errors++; $display("FAIL reset_index: got %0d, required 0", match_index); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_string();
    send_pattern("abc", 1'b1);
    wait_result();
  endtask

  task automatic test_plain_hit();
    send_string("hello world");
    send_pattern("wor", 1'b1);
    wait_result();
  endtask

  task automatic test_anchors();
    send_pattern("^wor", 1'b1);
    wait_result();
    send_pattern("^orl", 1'b1);
    wait_result();
    send_pattern("llo$", 1'b1);
    wait_result();
  endtask

  task automatic test_wildcard();
    send_string("abcabd");
    send_pattern("ab.", 1'b1);
    wait_result();
    send_pattern(".bd$", 1'b1);
    wait_result();
  endtask

  task automatic test_boundary();
    string s = "";
    for (int i = 0; i < 32; i++) s = {s, "a"};
    s = {s, "b"};
    send_string(s);
    send_pattern("b", 1'b1);
    wait_result();
  endtask

  task automatic test_back_to_back();
    send_string("the cat sat");
    send_pattern("cat", 1'b1);
    wait_result();
    send_pattern("dog", 1'b1);
    wait_result();
    send_pattern("sat$", 1'b1);
    wait_result();
  endtask

  task automatic test_reset_search();
    bit seen = 1'b0;
    send_string("abcdefghijklmnopqrst");
    send_pattern("zz", 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || match !== 1'b0 || match_index !== 5'd0) begin
      errors++;
      $display("FAIL reset_search_outputs: got %0b/%0b/%0d, required 0/0/0", valid, match, match_index);
    end
    @(negedge clk);
    reset     = 1'b1;
    model_str = "";
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_search_no_valid: got valid=1 after abort, required 0");
    end
    send_pattern("a", 1'b1);
    wait_result();
  endtask

  initial begin
    test_reset();
    test_no_string();
    test_plain_hit();
    test_anchors();
    test_wildcard();
    test_boundary();
    test_back_to_back();
    test_reset_search();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
